mc_pi_estimator: RTL and testbench

MC_PI_ESTIMATOR -- requirements
Module: mc_pi_estimator

---
 rtl/mc_pi_estimator_if.sv | 25 ++
 rtl/mc_pi_estimator.sv | 118 +++++++++++
 tb/tb_mc_pi_estimator.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_pi_estimator_if.sv
// Request/response bundle for the Monte Carlo pi estimator: run control,
// the (x,y) sample stream and the running results.
interface mc_pi_estimator_if;
   logic        start;
   logic [15:0] num_samples;
   logic        in_valid;
   logic [7:0]  x;
   logic [7:0]  y;
   logic        in_ready;
   logic        busy;
   logic        done;
   logic [16:0] hits;
   logic [16:0] total;
   logic [10:0] pi_est;

   modport master (
      output start, num_samples, in_valid, x, y,
      input  in_ready, busy, done, hits, total, pi_est
   );

   modport slave (
      input  start, num_samples, in_valid, x, y,
      output in_ready, busy, done, hits, total, pi_est
   );
endinterface

// File: rtl/mc_pi_estimator.sv
// Counts (x,y) samples falling inside the quarter circle of radius 256 and
// produces pi ~= 4*hits/total in Q3.8 with a bit-serial restoring divider.
module mc_pi_estimator (
   input  logic              clk,
   input  logic              rst,
   mc_pi_estimator_if.slave  bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_DIV   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [16:0] target_q;
   logic [16:0] hits_q;
   logic [16:0] total_q;
   logic [10:0] pi_q;
   logic [16:0] sum_q;
   logic        sum_vld_q;
   logic        drain_cnt_q;
   logic [4:0]  div_cnt_q;
   logic [26:0] quo_q;
   logic [16:0] rem_q;

   logic        in_ready;
   logic        accept;
   logic [15:0] x_sq;
   logic [15:0] y_sq;
   logic [16:0] sq_sum;
   logic [17:0] trial;
   logic        qbit;
   logic [16:0] rem_next;
   logic [26:0] quo_next;

   assign in_ready = (state_q == S_RUN) && (total_q < target_q);
   assign accept   = bus.in_valid && in_ready;

   assign x_sq   = bus.x * bus.x;
   assign y_sq   = bus.y * bus.y;
   assign sq_sum = {1'b0, x_sq} + {1'b0, y_sq};

   // quo_q shifts the dividend out at the top while quotient bits enter at the bottom
   assign trial    = {rem_q, quo_q[26]};
   assign qbit     = trial >= {1'b0, total_q};
   assign rem_next = qbit ? 17'(trial - {1'b0, total_q}) : trial[16:0];
   assign quo_next = {quo_q[25:0], qbit};

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN:   if (accept && (total_q + 17'd1 == target_q)) state_d = S_DRAIN;
         S_DRAIN: if (drain_cnt_q) state_d = S_DIV;
         S_DIV:   if (div_cnt_q == 5'd26) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         target_q    <= '0;
         hits_q      <= '0;
         total_q     <= '0;
         pi_q        <= '0;
         sum_q       <= '0;
         sum_vld_q   <= 1'b0;
         drain_cnt_q <= 1'b0;
         div_cnt_q   <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
      end else begin
         state_q     <= state_d;
         sum_vld_q   <= accept;
         drain_cnt_q <= (state_q == S_DRAIN) ? ~drain_cnt_q : 1'b0;

         if (accept) begin
            sum_q   <= sq_sum;
            total_q <= total_q + 17'd1;
         end

         if (sum_vld_q && (sum_q < 17'h10000))
            hits_q <= hits_q + 17'd1;

         // Both pipeline stages have settled by the second drain cycle
         if (state_q == S_DRAIN && drain_cnt_q) begin
            quo_q     <= {hits_q, 10'b0};
            rem_q     <= '0;
            div_cnt_q <= '0;
         end

         if (state_q == S_DIV) begin
            quo_q     <= quo_next;
            rem_q     <= rem_next;
            div_cnt_q <= div_cnt_q + 5'd1;
            if (div_cnt_q == 5'd26)
               pi_q <= quo_next[10:0];
         end

         if (state_q == S_IDLE && bus.start) begin
            target_q  <= (bus.num_samples == 16'd0) ? 17'h10000 : {1'b0, bus.num_samples};
            hits_q    <= '0;
            total_q   <= '0;
            pi_q      <= '0;
            sum_vld_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.hits     = hits_q;
   assign bus.total    = total_q;
   assign bus.pi_est   = pi_q;
endmodule

// File: tb/tb_mc_pi_estimator.sv
// Directed bench for mc_pi_estimator: a cycle-level reference model of the
// run/result behaviour is compared against the DUT on every falling edge.
module tb_mc_pi_estimator;
   logic clk = 1'b0;
   logic rst;
   mc_pi_estimator_if bus();

   mc_pi_estimator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // reference model state
   bit m_busy    = 1'b0;
   int m_acc     = 0;
   int m_target  = 0;
   int m_hits    = 0;
   int m_done_at = -1;
   int sh_hits   = 0;
   int sh_pi     = 0;
   int last_acc  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 50)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   // Model: follows the run rules at the transaction level, timing pinned by
   // "done exactly 30 cycles after the last accepted pair".
   initial forever begin
      bit was_done;
      int sq;
      @(posedge clk);
      cyc++;
      if (rst === 1'b1) begin
         m_busy = 1'b0; m_acc = 0; m_target = 0; m_hits = 0;
         m_done_at = -1; sh_hits = 0; sh_pi = 0;
      end else begin
         was_done = m_busy && (cyc - 1 == m_done_at);
         if (!m_busy && bus.start === 1'b1) begin
            m_busy    = 1'b1;
            m_target  = (bus.num_samples == 16'd0) ? 65536 : int'(bus.num_samples);
            m_acc     = 0; m_hits = 0; sh_hits = 0; sh_pi = 0;
            m_done_at = -1;
         end else if (m_busy && m_acc < m_target && bus.in_valid === 1'b1) begin
            m_acc++;
            sq = int'(bus.x) * int'(bus.x) + int'(bus.y) * int'(bus.y);
            if (sq < 65536) m_hits++;
            if (m_acc == m_target) m_done_at = (cyc - 1) + 30;
         end
         if (was_done) m_busy = 1'b0;
         if (m_busy && cyc == m_done_at) begin
            sh_hits = m_hits;
            sh_pi   = (m_hits * 1024) / m_acc;
         end
      end
   end

   initial forever begin
      bit exp_done;
      @(negedge clk);
      if (chk_en) begin
         exp_done = m_busy && (cyc == m_done_at);
         check("in_ready", 32'(bus.in_ready), 32'(m_busy && (m_acc < m_target)));
         check("busy",     32'(bus.busy),     32'(m_busy));
         check("done",     32'(bus.done),     32'(exp_done));
         check("total",    32'(bus.total),    32'(m_acc));
         check("pi_est",   32'(bus.pi_est),   32'(sh_pi));
         if (!m_busy || exp_done)
            check("hits", 32'(bus.hits), 32'(sh_hits));
      end
   end

   task automatic start_run(input logic [15:0] ns);
      bus.start = 1'b1;
      bus.num_samples = ns;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.num_samples = 16'($urandom);
   endtask

   task automatic send(input logic [7:0] px, input logic [7:0] py);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.x = px;
      bus.y = py;
      forever begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            last_acc = cyc;
            @(posedge clk); #1;
            break;
         end
         n++;
         if (n > 100) begin
            fail_now("send_timeout");
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.x = 8'($urandom);
      bus.y = 8'($urandom);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.done !== 1'b1 && n < budget);
      if (bus.done !== 1'b1) fail_now("wait_done");
   endtask

   task automatic expect_results(input string tag, input int h, input int t, input int p);
      check({tag, "_hits"},   32'(bus.hits),   32'(h));
      check({tag, "_total"},  32'(bus.total),  32'(t));
      check({tag, "_pi_est"}, 32'(bus.pi_est), 32'(p));
   endtask

   logic [7:0] pa_x [4] = '{8'd0, 8'd255, 8'd181, 8'd182};
   logic [7:0] pa_y [4] = '{8'd0, 8'd255, 8'd181, 8'd182};

   initial begin
      int seen;
      rst = 1'b1;
      bus.start = 1'b0; bus.num_samples = '0;
      bus.in_valid = 1'b0; bus.x = '0; bus.y = '0;

      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expect_results("reset", 0, 0, 0);
      check("reset_in_ready", 32'(bus.in_ready), 32'd0);
      check("reset_busy",     32'(bus.busy),     32'd0);
      check("reset_done",     32'(bus.done),     32'd0);
      idle_cycles(2);

      // back-to-back run of four pairs
      start_run(16'd4);
      for (int i = 0; i < 4; i++) send(pa_x[i], pa_y[i]);
      wait_done(100);
      check("a_latency", 32'(cyc - last_acc), 32'd30);
      expect_results("a", 2, 4, 512);
      $display("run A: hits=%0d total=%0d pi_est=%0d", bus.hits, bus.total, bus.pi_est);
      @(posedge clk); #1;

      // same pairs with gaps, start pulses during RUN and in the DONE cycle
      start_run(16'd4);
      for (int i = 0; i < 4; i++) begin
         idle_cycles($urandom_range(0, 3));
         if (i == 1) start_run(16'd9);
         send(pa_x[i], pa_y[i]);
      end
      check("b_in_ready_after_last", 32'(bus.in_ready), 32'd0);
      wait_done(100);
      check("b_latency", 32'(cyc - last_acc), 32'd30);
      expect_results("b", 2, 4, 512);
      bus.start = 1'b1;
      bus.num_samples = 16'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      idle_cycles(3);
      check("b_busy_after_done_start", 32'(bus.busy), 32'd0);
      expect_results("b_hold", 2, 4, 512);
      $display("run B: hits=%0d total=%0d pi_est=%0d", bus.hits, bus.total, bus.pi_est);

      // num_samples = 0 means 65536 pairs
      start_run(16'd0);
      for (int i = 0; i < 65536; i++) send(8'd0, 8'd0);
      wait_done(100);
      check("c_latency", 32'(cyc - last_acc), 32'd30);
      expect_results("c", 65536, 65536, 1024);
      $display("run C: hits=%0d total=%0d pi_est=%0d", bus.hits, bus.total, bus.pi_est);
      @(posedge clk); #1;

      // reset while the divider is running
      start_run(16'd3);
      for (int i = 0; i < 3; i++) send(8'd10, 8'd10);
      idle_cycles(8);
      check("d_busy_in_div", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expect_results("d_rst", 0, 0, 0);
      check("d_rst_busy",     32'(bus.busy),     32'd0);
      check("d_rst_in_ready", 32'(bus.in_ready), 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done !== 1'b0) seen = 1;
      end
      check("d_no_done_after_rst", 32'(seen), 32'd0);
      $display("run D: aborted in DIV, done_seen=%0d", seen);
      @(posedge clk); #1;

      // single-sample run after the abort: 255^2 = 65025 is inside
      start_run(16'd1);
      send(8'd255, 8'd0);
      wait_done(100);
      check("e_latency", 32'(cyc - last_acc), 32'd30);
      expect_results("e", 1, 1, 1024);
      $display("run E: hits=%0d total=%0d pi_est=%0d", bus.hits, bus.total, bus.pi_est);
      @(posedge clk); #1;
      idle_cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
